// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR): one register stage per shift-amount bit,
// largest shift first, valid/ready on both sides with collapsing bubbles.
module pipelined_shifter #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned TAG_W = 4,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    // Stage registers
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [1:0]       mode_q [SHW];
    logic [TAG_W-1:0] tag_q  [SHW];
    logic             zero_q;

    // Per-stage register inputs
    logic [SHW-1:0]   adv_c;
    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [1:0]       src_mode [SHW];
    logic [TAG_W-1:0] src_tag  [SHW];
    logic [WIDTH-1:0] nxt_data [SHW];

    // Shift by the fixed distance owned by one stage.
    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       mode,
                                                  input int unsigned      stage);
        int unsigned      k;
        logic [WIDTH-1:0] r;
        k = 1 << (SHW - 1 - stage);
        case (mode)
            MODE_SLL: r = d << k;
            MODE_SRL: r = d >> k;
            MODE_SRA: r = $unsigned($signed(d) >>> k);
            default:  r = (d >> k) | (d << (WIDTH - k));
        endcase
        return r;
    endfunction

    // A stage may load when it is empty or its successor is moving.
    always_comb begin : advance
        adv_c = '0;
        adv_c[SHW-1] = !valid_q[SHW-1] || out_ready;
        for (int s = SHW - 2; s >= 0; s--) begin
            adv_c[s] = !valid_q[s] || adv_c[s+1];
        end
    end

    assign in_ready = adv_c[0] && !rst;

    always_comb begin : stage_inputs
        src_valid    = '0;
        src_valid[0] = in_valid && in_ready;
        src_data[0]  = in_data;
        src_amt[0]   = in_amt;
        src_mode[0]  = in_mode;
        src_tag[0]   = in_tag;
        for (int s = 1; s < SHW; s++) begin
            src_valid[s] = valid_q[s-1];
            src_data[s]  = data_q[s-1];
            src_amt[s]   = amt_q[s-1];
            src_mode[s]  = mode_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end
    end

    always_comb begin : stage_shift
        for (int s = 0; s < SHW; s++) begin
            nxt_data[s] = src_amt[s][SHW-1-s] ? shift_op(src_data[s], src_mode[s], s)
                                              : src_data[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int s = 0; s < SHW; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                mode_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < SHW; s++) begin
                if (adv_c[s]) begin
                    valid_q[s] <= src_valid[s];
                    data_q[s]  <= nxt_data[s];
                    amt_q[s]   <= src_amt[s];
                    mode_q[s]  <= src_mode[s];
                    tag_q[s]   <= src_tag[s];
                end
            end
            // Zero flag travels with the final stage load and is low on bubbles.
            if (adv_c[SHW-1]) begin
                zero_q <= src_valid[SHW-1] && (nxt_data[SHW-1] == '0);
            end
        end
    end

    // The last stage's amount and mode are carried but have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt_q[SHW-1], mode_q[SHW-1]};

    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_tag   = tag_q[SHW-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: a 16-bit and a 32-bit instance,
// vector tables, directed flow-control sequences and a queue scoreboard.
module tb_pipelined_shifter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_out_zero;
    logic [15:0] a_in_data = '0, a_out_data, a_exp = '0;
    logic [3:0]  a_in_amt = '0, a_in_tag = '0, a_out_tag;
    logic [1:0]  a_in_mode = '0;

    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_zero;
    logic [31:0] b_in_data = '0, b_out_data, b_exp = '0;
    logic [4:0]  b_in_amt = '0;
    logic [1:0]  b_in_tag = '0, b_out_tag, b_in_mode = '0;

    pipelined_shifter #(.WIDTH(16), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_amt(a_in_amt), .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_zero(a_out_zero), .out_tag(a_out_tag));

    pipelined_shifter #(.WIDTH(32), .TAG_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_amt(b_in_amt), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_zero(b_out_zero), .out_tag(b_out_tag));

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } sb_t;

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  amt;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    sb_t q16[$];
    sb_t q32[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-by-bit reference: each result bit picks its source bit directly.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                              input int amt, input logic [1:0] mode);
        logic [31:0] r;
        logic [31:0] bitv;
        int j;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (mode)
                2'd0: begin j = i - amt; bitv = (j >= 0) ? ((d >> j) & 32'd1) : 32'd0; end
                2'd1: begin j = i + amt; bitv = (j < w) ? ((d >> j) & 32'd1) : 32'd0; end
                2'd2: begin j = i + amt; bitv = (j < w) ? ((d >> j) & 32'd1) : ((d >> (w - 1)) & 32'd1); end
                default: begin j = (i + amt) % w; bitv = (d >> j) & 32'd1; end
            endcase
            r = r | (bitv << i);
        end
        return r;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                if (q16.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_out: got data %h tag %h with nothing expected", a_out_data, a_out_tag);
                end else begin
                    e = q16.pop_front();
                    check("a_data", 32'(a_out_data), e.data);
                    check("a_zero", 32'(a_out_zero), 32'(e.data == 0));
                    check("a_tag", 32'(a_out_tag), 32'(e.tag));
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (q32.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_out: got data %h tag %h with nothing expected", b_out_data, b_out_tag);
                end else begin
                    e = q32.pop_front();
                    check("b_data", b_out_data, e.data);
                    check("b_zero", 32'(b_out_zero), 32'(e.data == 0));
                    check("b_tag", 32'(b_out_tag), 32'(e.tag));
                end
            end
            if (a_in_valid && a_in_ready) q16.push_back('{32'(a_exp), a_in_tag});
            if (b_in_valid && b_in_ready) q32.push_back('{b_exp, 4'(b_in_tag)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic [1:0] m, input logic [3:0] amt, input logic [15:0] d,
                           input logic [3:0] tag, input logic [15:0] exp);
        a_in_valid = 1; a_in_mode = m; a_in_amt = amt; a_in_data = d; a_in_tag = tag; a_exp = exp;
    endtask

    task automatic b_drive(input logic [1:0] m, input logic [4:0] amt, input logic [31:0] d,
                           input logic [1:0] tag, input logic [31:0] exp);
        b_in_valid = 1; b_in_mode = m; b_in_amt = amt; b_in_data = d; b_in_tag = tag; b_exp = exp;
    endtask

    task automatic a_send(input logic [1:0] m, input logic [3:0] amt, input logic [15:0] d,
                          input logic [3:0] tag, input logic [15:0] exp);
        logic acc;
        acc = 0;
        a_drive(m, amt, d, tag, exp);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = a_in_ready;
            step();
        end
        a_in_valid = 0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL a_send_timeout: tag %h never accepted", tag);
        end
    endtask

    task automatic b_send(input logic [1:0] m, input logic [4:0] amt, input logic [31:0] d,
                          input logic [1:0] tag, input logic [31:0] exp);
        logic acc;
        acc = 0;
        b_drive(m, amt, d, tag, exp);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = b_in_ready;
            step();
        end
        b_in_valid = 0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL b_send_timeout: tag %h never accepted", tag);
        end
    endtask

    task automatic drain();
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        for (int c = 0; c < 200 && (q16.size() != 0 || q32.size() != 0); c++) step();
        check("a_drain_left", 32'(q16.size()), 32'd0);
        check("b_drain_left", 32'(q32.size()), 32'd0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t t16[16];
    vec_t t32[5];
    logic rand_done = 0;

    initial begin
        int fa, fb, acc, run, cnt;
        logic got, seen;
        logic [1:0] m;
        logic [3:0] amt;
        logic [15:0] d;

        t16[0]  = '{2'd0, 5'd15, 32'h0001, 32'h8000};
        t16[1]  = '{2'd1, 5'd4,  32'h8000, 32'h0800};
        t16[2]  = '{2'd2, 5'd4,  32'h8000, 32'hF800};
        t16[3]  = '{2'd3, 5'd4,  32'h1234, 32'h4123};
        t16[4]  = '{2'd0, 5'd1,  32'h8000, 32'h0000};
        t16[5]  = '{2'd0, 5'd0,  32'hA5C3, 32'hA5C3};
        t16[6]  = '{2'd1, 5'd0,  32'hA5C3, 32'hA5C3};
        t16[7]  = '{2'd2, 5'd0,  32'hA5C3, 32'hA5C3};
        t16[8]  = '{2'd3, 5'd0,  32'hA5C3, 32'hA5C3};
        t16[9]  = '{2'd2, 5'd15, 32'h7FFF, 32'h0000};
        t16[10] = '{2'd2, 5'd15, 32'hFFFF, 32'hFFFF};
        t16[11] = '{2'd3, 5'd15, 32'h0001, 32'h0002};
        t16[12] = '{2'd1, 5'd8,  32'hA5C3, 32'h00A5};
        t16[13] = '{2'd0, 5'd8,  32'hA5C3, 32'hC300};
        t16[14] = '{2'd2, 5'd3,  32'hA5C3, 32'hF4B8};
        t16[15] = '{2'd3, 5'd3,  32'hA5C3, 32'h74B8};
        t32[0]  = '{2'd2, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        t32[1]  = '{2'd3, 5'd1,  32'h00000001, 32'h80000000};
        t32[2]  = '{2'd0, 5'd31, 32'h00000001, 32'h80000000};
        t32[3]  = '{2'd1, 5'd31, 32'h80000000, 32'h00000001};
        t32[4]  = '{2'd3, 5'd16, 32'h12345678, 32'h56781234};

        // Reset state
        #1 rst = 1;
        #2;
        check("a_rst_valid", 32'(a_out_valid), 0);
        check("a_rst_data", 32'(a_out_data), 0);
        check("a_rst_zero", 32'(a_out_zero), 0);
        check("a_rst_tag", 32'(a_out_tag), 0);
        check("a_rst_ready", 32'(a_in_ready), 0);
        check("b_rst_valid", 32'(b_out_valid), 0);
        check("b_rst_data", b_out_data, 0);
        check("b_rst_ready", 32'(b_in_ready), 0);
        step(); step();
        rst = 0;
        @(negedge clk);
        check("a_ready_after_rst", 32'(a_in_ready), 1);
        check("b_ready_after_rst", 32'(b_in_ready), 1);
        step();

        // Latency from an empty pipe
        a_drive(2'd0, 4'd15, 16'h0001, 4'd1, 16'h8000);
        b_drive(2'd2, 5'd31, 32'h80000000, 2'd1, 32'hFFFFFFFF);
        @(negedge clk);
        check("a_lat_ready", 32'(a_in_ready), 1);
        check("b_lat_ready", 32'(b_in_ready), 1);
        step();
        a_in_valid = 0; b_in_valid = 0;
        fa = 0; fb = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (a_out_valid && fa == 0) fa = c;
            if (b_out_valid && fb == 0) fb = c;
            step();
        end
        check("a_latency", 32'(fa), 4);
        check("b_latency", 32'(fb), 5);

        // Vector tables, back to back
        for (int i = 0; i < 16; i++)
            a_send(t16[i].mode, t16[i].amt[3:0], t16[i].data[15:0], 4'(i), t16[i].exp[15:0]);
        for (int i = 0; i < 5; i++)
            b_send(t32[i].mode, t32[i].amt, t32[i].data, 2'(i), t32[i].exp);
        drain();

        // Eight back-to-back issues give eight consecutive results
        run = 0; seen = 0;
        fork
            for (int i = 0; i < 8; i++) a_send(2'(i % 4), 4'd0, 16'hA5C3, 4'(i), 16'hA5C3);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (a_out_valid) begin run++; seen = 1; end
                else if (seen) break;
            end
        join
        check("a_b2b_run", 32'(run), 8);
        drain();

        // Back-pressure: fill, stall, single-cycle release
        a_out_ready = 0; acc = 0;
        m = 2'($urandom_range(0, 3)); amt = 4'($urandom_range(0, 15)); d = 16'($urandom);
        a_drive(m, amt, d, 4'(acc), 16'(ref_shift(16, 32'(d), int'(amt), m)));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            got = a_in_ready;
            if (got) acc++;
            step();
            if (got) begin
                m = 2'($urandom_range(0, 3)); amt = 4'($urandom_range(0, 15)); d = 16'($urandom);
                a_drive(m, amt, d, 4'(acc), 16'(ref_shift(16, 32'(d), int'(amt), m)));
            end
        end
        check("a_bp_accepted", 32'(acc), 4);
        @(negedge clk);
        check("a_bp_ready_low", 32'(a_in_ready), 0);
        check("a_bp_valid", 32'(a_out_valid), 1);
        check("a_bp_head_data", 32'(a_out_data), q16[0].data);
        check("a_bp_head_tag", 32'(a_out_tag), 32'(q16[0].tag));
        step();
        @(negedge clk);
        check("a_bp_stable_data", 32'(a_out_data), q16[0].data);
        check("a_bp_stable_tag", 32'(a_out_tag), 32'(q16[0].tag));
        step();
        a_out_ready = 1;
        @(negedge clk);
        check("a_bp_release_in", 32'(a_in_ready), 1);
        check("a_bp_release_out", 32'(a_out_valid), 1);
        step();
        a_out_ready = 0; a_in_valid = 0;
        @(negedge clk);
        check("a_bp_full_again", 32'(a_in_ready), 0);
        step();
        drain();

        // Bubble collapse: A, two idle cycles, B, output stalled
        a_out_ready = 0;
        a_send(2'd0, 4'd1, 16'h0101, 4'd10, 16'h0202);
        step(); step();
        a_send(2'd1, 4'd1, 16'h0202, 4'd11, 16'h0101);
        step(); step(); step();
        @(negedge clk);
        check("a_bub_head_tag", 32'(a_out_tag), 10);
        check("a_bub_ready", 32'(a_in_ready), 1);
        step();
        a_out_ready = 1;
        @(negedge clk);
        check("a_bub_first", 32'({a_out_valid, a_out_tag}), 32'({1'b1, 4'd10}));
        step();
        @(negedge clk);
        check("a_bub_second", 32'({a_out_valid, a_out_tag}), 32'({1'b1, 4'd11}));
        step();
        drain();

        // Random traffic with random back-pressure on both instances
        fork
            while (!rand_done) begin
                step();
                if (!rand_done) begin
                    a_out_ready = ($urandom_range(0, 3) != 0);
                    b_out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join_none
        fork
            for (int i = 0; i < 100; i++) begin
                logic [1:0] rm; logic [3:0] ra; logic [15:0] rd;
                rm = 2'($urandom_range(0, 3)); ra = 4'($urandom_range(0, 15)); rd = 16'($urandom);
                if ($urandom_range(0, 3) == 0) step();
                a_send(rm, ra, rd, 4'(i), 16'(ref_shift(16, 32'(rd), int'(ra), rm)));
            end
            for (int i = 0; i < 60; i++) begin
                logic [1:0] rm; logic [4:0] ra; logic [31:0] rd;
                rm = 2'($urandom_range(0, 3)); ra = 5'($urandom_range(0, 31)); rd = $urandom;
                if ($urandom_range(0, 3) == 0) step();
                b_send(rm, ra, rd, 2'(i), ref_shift(32, rd, int'(ra), rm));
            end
        join
        rand_done = 1;
        step(); step();
        drain();

        // Reset with three operations in flight
        a_out_ready = 0;
        a_send(2'd0, 4'd2, 16'h0F0F, 4'd3, 16'h3C3C);
        a_send(2'd1, 4'd3, 16'hF000, 4'd4, 16'h1E00);
        a_send(2'd3, 4'd8, 16'h1234, 4'd5, 16'h3412);
        for (int c = 0; c < 10 && !a_out_valid; c++) step();
        @(negedge clk);
        check("a_mid_valid_before", 32'(a_out_valid), 1);
        #1 rst = 1;
        #1;
        check("a_mid_rst_valid", 32'(a_out_valid), 0);
        check("a_mid_rst_data", 32'(a_out_data), 0);
        check("a_mid_rst_tag", 32'(a_out_tag), 0);
        check("a_mid_rst_zero", 32'(a_out_zero), 0);
        check("a_mid_rst_ready", 32'(a_in_ready), 0);
        q16.delete();
        q32.delete();
        step(); step();
        @(negedge clk);
        #2 rst = 0;
        step();
        a_out_ready = 1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_out_valid) cnt++;
            step();
        end
        check("a_no_stale", 32'(cnt), 0);
        a_send(2'd2, 4'd2, 16'hFFF0, 4'd6, 16'hFFFC);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter. Generalises the single-cycle 16-bit SLL/SRA shifter to any power-of-two WIDTH and four modes: SLL, SRL, SRA and ROR.
- Uses one register stage per shift-amount bit, with valid/ready handshakes on both sides.
- Sits between the decode/issue logic and writeback in the execute path, so shift operations run at full clock rate with back-pressure support.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, never overridden.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts the operation this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift amount, 0..WIDTH-1.
- in_mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR.
- in_tag  input  TAG_W  passed through unchanged.
- out_valid  output  1  the result is valid.
- out_ready  input  1  the consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0; registered alongside out_data.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Structure:
  - SHW stages, s = 0..SHW-1.
  - Stage s applies the shift of 2^(SHW-1-s) when amt bit (SHW-1-s) is set, so the MSB is applied first.
  - Each stage register holds: valid, data, the remaining amt, mode, tag.
  - Stage SHW-1 drives all out_* ports directly.
- Mode rules per stage, for a shift of k:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the stage input's MSB.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Amount 0 gives out_data == in_data in every mode.
- Handshake:
  - A transfer occurs on the input when in_valid && in_ready.
  - A transfer occurs on the output when out_valid && out_ready.
  - Input signals may change freely when no transfer occurs.
- Advance rule:
  - adv[SHW-1] = !valid[SHW-1] || out_ready.
  - adv[s] = !valid[s] || adv[s+1].
  - in_ready = adv[0], purely combinational.
  - Bubbles collapse: an empty stage accepts from upstream even while later stages are stalled.
- Stall: when a stage does not advance, its register holds (data, amt, mode, tag and valid unchanged). out_* stay stable while out_valid && !out_ready.
- Timing:
  - Latency is SHW cycles: an operation accepted on edge N appears on out_* after edge N+SHW-1 and is observable in that cycle.
  - Throughput is one operation per cycle with out_ready held high.
  - Capacity is SHW operations in flight; in_ready deasserts only when all stages are valid and out_ready is low.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle; no bubble is inserted.
- Ordering: strictly FIFO; tags leave in acceptance order.
- Reset:
  - On rst assertion, immediately and regardless of clk, all stage valid bits, data and tag are cleared to 0. This gives out_valid=0, out_data=0, out_zero=0, out_tag=0.
  - in_ready is forced to 0 while rst is high, and becomes 1 in the first cycle after deassertion.
  - Reset mid-operation discards all in-flight operations with no partial output.
- out_zero is computed from the final stage's data at its register load. It is 0 whenever out_valid=0.
- An in_mode outside 00..11 cannot occur (2 bits, all encoded).

Test Plan:
- WIDTH=16, out_ready=1:
  - SLL 0x0001 amt 15 -> 0x8000.
  - SRL 0x8000 amt 4 -> 0x0800.
  - SRA 0x8000 amt 4 -> 0xF800.
  - ROR 0x1234 amt 4 -> 0x4123.
  - Each out_valid exactly 4 cycles after acceptance.
  - SLL 0x8000 amt 1 -> 0x0000 with out_zero=1.
- Amount 0, all modes, operand 0xA5C3 -> 0xA5C3. Back-to-back issue of 8 operations gives 8 consecutive out_valid cycles with tags 0..7 in order.
- Back-pressure:
  - Hold out_ready=0 and issue continuously: exactly 4 accepted, then in_ready=0 with out_* stable.
  - Raise out_ready for one cycle: one result leaves and one new input is accepted in that same cycle.
  - No loss or reordering over 100 random operations against a reference model.
- Bubble collapse: issue A, idle 2 cycles, issue B, out_ready=0. A sits at the output and B reaches stage 2 without gaps. Release: A then B on consecutive cycles.
- Reset mid-stream: with 3 operations in flight, assert rst asynchronously between edges. out_valid, out_data and out_tag drop to 0 immediately and in_ready=0. After deassertion no stale result appears, and a new SRA 0xFFF0 amt 2 -> 0xFFFC.
- WIDTH=32, TAG_W=2 instance:
  - SRA 0x80000000 amt 31 -> 0xFFFFFFFF.
  - ROR 0x00000001 amt 1 -> 0x80000000.
  - Latency 5 cycles; random operations are checked against the reference model.
